// File: rtl/game_sequencer_if.sv
// Command channel between a game controller and game_sequencer.
interface game_sequencer_if #(
  parameter int unsigned LEN_W = 6
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic             cmd_load;
  logic [3:0]       cmd_value;
  logic [LEN_W-1:0] cmd_len;

  modport master (
    output cmd_valid, cmd_mode, cmd_load, cmd_value, cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_load, cmd_value, cmd_len,
    output cmd_ready
  );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer: runs commanded up/down counter segments, tallies win/lose
// events and halts on GAMEOVER until game_clr.
// Optional macro GAME_SEQ_CHECK_EN adds a sticky count-prediction check.
module game_sequencer #(
  parameter int unsigned LEN_W = 6
) (
  input  logic       clk,
  input  logic       reset,
  game_sequencer_if.slave cmd,
  input  logic       game_clr,
  input  logic       WINNER,
  input  logic       LOSER,
  input  logic       GAMEOVER,
  input  logic [1:0] WHO,
  input  logic [3:0] count,
  output logic [1:0] control_value,
  output logic       INIT,
  output logic [3:0] count_input,
  output logic       ctr_reset,
  output logic       busy,
  output logic       done,
  output logic [1:0] result_who,
  output logic [3:0] win_seen,
  output logic [3:0] lose_seen,
  output logic       check_err
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StHalt} state_e;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [3:0]       value_q, value_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [1:0]       who_q, who_d;
  logic [3:0]       win_q, win_d, lose_q, lose_d;
  logic             clr_hit;
  logic             cmd_ready_q, busy_q, done_q, init_q, ctr_reset_q;

  // Next-state, segment latching, tallies and GAMEOVER override.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    value_d = value_q;
    rem_d   = rem_q;
    who_d   = who_q;
    win_d   = win_q;
    lose_d  = lose_q;
    clr_hit = 1'b0;

    if (state_q == StLoad || state_q == StRun) begin
      if (WINNER && win_q != 4'hf) win_d = win_q + 4'd1;
      if (LOSER && lose_q != 4'hf) lose_d = lose_q + 4'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (cmd.cmd_valid && !GAMEOVER) begin
          mode_d  = cmd.cmd_mode;
          value_d = cmd.cmd_value;
          rem_d   = (cmd.cmd_len == '0) ? LEN_W'(1) : cmd.cmd_len;
          state_d = cmd.cmd_load ? StLoad : StRun;
        end
      end
      StLoad: state_d = StRun;
      StRun: begin
        rem_d = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) state_d = StIdle;
      end
      StHalt: begin
        if (game_clr) begin
          clr_hit = 1'b1;
          win_d   = '0;
          lose_d  = '0;
          who_d   = '0;
          state_d = StIdle;
        end
      end
    endcase

    // GAMEOVER wins over segment end and over a command offered in IDLE.
    if (GAMEOVER && state_q != StHalt) begin
      state_d = StHalt;
      who_d   = WHO;
    end
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      mode_q      <= '0;
      value_q     <= '0;
      rem_q       <= '0;
      who_q       <= '0;
      win_q       <= '0;
      lose_q      <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      init_q      <= 1'b0;
      ctr_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      value_q     <= value_d;
      rem_q       <= rem_d;
      who_q       <= who_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
      cmd_ready_q <= (state_d == StIdle);
      busy_q      <= (state_d == StLoad) || (state_d == StRun);
      done_q      <= (state_d == StHalt);
      init_q      <= (state_d == StLoad);
      ctr_reset_q <= clr_hit;
    end
  end

  assign cmd.cmd_ready = cmd_ready_q;
  assign control_value = mode_q;
  assign count_input   = value_q;
  assign INIT          = init_q;
  assign ctr_reset     = ctr_reset_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign result_who    = who_q;
  assign win_seen      = win_q;
  assign lose_seen     = lose_q;

`ifdef GAME_SEQ_CHECK_EN
  logic [3:0] prev_count_q;
  logic       prev_run_q;
  logic       err_q;
  logic [3:0] step;

  // Mode step as a mod-16 addend (-1 = +15, -2 = +14).
  always_comb begin
    case (mode_q)
      2'b00:   step = 4'd1;
      2'b01:   step = 4'd2;
      2'b10:   step = 4'd15;
      default: step = 4'd14;
    endcase
  end

  // Compare count against last cycle's count plus step, from 2nd RUN cycle on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_count_q <= '0;
      prev_run_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      prev_count_q <= count;
      prev_run_q   <= (state_q == StRun);
      if (clr_hit) begin
        err_q <= 1'b0;
      end else if (state_q == StRun && prev_run_q && count != prev_count_q + step) begin
        err_q <= 1'b1;
      end
    end
  end

  assign check_err = err_q;
`else
  logic unused_count;
  assign unused_count = ^count;
  assign check_err    = 1'b0;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer.
module tb_game_sequencer;

  logic       clk;
  logic       reset;
  logic       game_clr;
  logic       WINNER, LOSER, GAMEOVER;
  logic [1:0] WHO;
  logic [3:0] count;
  logic [1:0] control_value;
  logic       INIT;
  logic [3:0] count_input;
  logic       ctr_reset, busy, done;
  logic [1:0] result_who;
  logic [3:0] win_seen, lose_seen;
  logic       check_err;

  int errors = 0;
  int checks = 0;

  game_sequencer_if #(.LEN_W(6)) cmd_if ();

  game_sequencer #(.LEN_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd          (cmd_if.slave),
    .game_clr     (game_clr),
    .WINNER       (WINNER),
    .LOSER        (LOSER),
    .GAMEOVER     (GAMEOVER),
    .WHO          (WHO),
    .count        (count),
    .control_value(control_value),
    .INIT         (INIT),
    .count_input  (count_input),
    .ctr_reset    (ctr_reset),
    .busy         (busy),
    .done         (done),
    .result_who   (result_who),
    .win_seen     (win_seen),
    .lose_seen    (lose_seen),
    .check_err    (check_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Status vector: {cmd_ready, busy, done, INIT, ctr_reset}
  logic [4:0] st;
  assign st = {cmd_if.cmd_ready, busy, done, INIT, ctr_reset};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic l, input logic [3:0] v,
                      input logic [5:0] n);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_mode  = m;
    cmd_if.cmd_load  = l;
    cmd_if.cmd_value = v;
    cmd_if.cmd_len   = n;
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({st, control_value, count_input, result_who, win_seen, lose_seen, check_err} !== '0) begin
      errors++;
      $display("FAIL reset_values: got st=%b cv=%b ci=%h rw=%b w=%h l=%h e=%b want all zero",
               st, control_value, count_input, result_who, win_seen, lose_seen, check_err);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (st !== 5'b10000) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 10000", st);
    end
  endtask

  task automatic test_load_run();
    send(2'b00, 1'b1, 4'hd, 6'd4);
    checks++;
    if ({st, count_input} !== {5'b01010, 4'hd}) begin
      errors++;
      $display("FAIL load_init: got st=%b ci=%h want 01010 d", st, count_input);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({st, control_value} !== {5'b01000, 2'b00}) begin
        errors++;
        $display("FAIL load_run_cycle%0d: got st=%b cv=%b want 01000 00", i, st, control_value);
      end
    end
    tick();
    checks++;
    if (st !== 5'b10000) begin
      errors++;
      $display("FAIL load_run_idle: got %b want 10000", st);
    end
  endtask

  task automatic test_zero_len();
    send(2'b01, 1'b0, 4'h3, 6'd0);
    checks++;
    if ({st, control_value} !== {5'b01000, 2'b01}) begin
      errors++;
      $display("FAIL zero_len_run: got st=%b cv=%b want 01000 01", st, control_value);
    end
    tick();
    checks++;
    if ({st, control_value} !== {5'b10000, 2'b01}) begin
      errors++;
      $display("FAIL zero_len_idle: got st=%b cv=%b want 10000 01", st, control_value);
    end
  endtask

  task automatic test_saturate();
    send(2'b00, 1'b0, 4'h0, 6'd20);
    WINNER = 1'b1;
    LOSER  = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i == 2) LOSER = 1'b0;
      if (i == 14) begin
        checks++;
        if (win_seen !== 4'd14) begin
          errors++;
          $display("FAIL win_count14: got %0d want 14", win_seen);
        end
      end
    end
    WINNER = 1'b0;
    checks++;
    if ({win_seen, lose_seen} !== {4'd15, 4'd2}) begin
      errors++;
      $display("FAIL win_saturate: got w=%0d l=%0d want w=15 l=2", win_seen, lose_seen);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({st, win_seen} !== {5'b10000, 4'd15}) begin
      errors++;
      $display("FAIL saturate_end: got st=%b w=%0d want 10000 15", st, win_seen);
    end
  endtask

  task automatic test_gameover();
    send(2'b11, 1'b0, 4'h0, 6'd10);
    tick();
    GAMEOVER = 1'b1;
    WHO      = 2'b10;
    tick();
    GAMEOVER = 1'b0;
    WHO      = 2'b00;
    checks++;
    if ({st, result_who, control_value} !== {5'b00100, 2'b10, 2'b11}) begin
      errors++;
      $display("FAIL gameover_halt: got st=%b rw=%b cv=%b want 00100 10 11",
               st, result_who, control_value);
    end
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_load  = 1'b1;
    tick();
    tick();
    checks++;
    if ({st, win_seen, lose_seen} !== {5'b00100, 4'd15, 4'd2}) begin
      errors++;
      $display("FAIL halt_ignores_cmd: got st=%b w=%0d l=%0d want 00100 15 2",
               st, win_seen, lose_seen);
    end
    cmd_if.cmd_valid = 1'b0;
    game_clr = 1'b1;
    tick();
    game_clr = 1'b0;
    checks++;
    if ({st, result_who, win_seen, lose_seen, check_err} !== {5'b10001, 2'b00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL game_clr: got st=%b rw=%b w=%0d l=%0d e=%b want 10001 00 0 0 0",
               st, result_who, win_seen, lose_seen, check_err);
    end
    tick();
    checks++;
    if (st !== 5'b10000) begin
      errors++;
      $display("FAIL ctr_reset_one_cycle: got %b want 10000", st);
    end
  endtask

  task automatic test_gameover_idle();
    // game_clr outside HALT does nothing.
    game_clr = 1'b1;
    tick();
    game_clr = 1'b0;
    checks++;
    if (st !== 5'b10000) begin
      errors++;
      $display("FAIL clr_outside_halt: got %b want 10000", st);
    end
    // GAMEOVER beats an offered command.
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_mode  = 2'b01;
    cmd_if.cmd_load  = 1'b1;
    cmd_if.cmd_value = 4'h7;
    GAMEOVER         = 1'b1;
    WHO              = 2'b01;
    tick();
    cmd_if.cmd_valid = 1'b0;
    GAMEOVER         = 1'b0;
    checks++;
    if ({st, result_who, control_value} !== {5'b00100, 2'b01, 2'b11}) begin
      errors++;
      $display("FAIL gameover_over_accept: got st=%b rw=%b cv=%b want 00100 01 11",
               st, result_who, control_value);
    end
    game_clr = 1'b1;
    tick();
    game_clr = 1'b0;
    tick();
  endtask

  task automatic test_check();
    logic exp_err;
`ifdef GAME_SEQ_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    send(2'b10, 1'b0, 4'h0, 6'd4);
    count = 4'd5;
    tick();
    count = 4'd4;
    tick();
    count = 4'd3;
    tick();
    count = 4'd7;
    checks++;
    if (check_err !== 1'b0) begin
      errors++;
      $display("FAIL check_clean_steps: got %b want 0", check_err);
    end
    tick();
    checks++;
    if (check_err !== exp_err) begin
      errors++;
      $display("FAIL check_bad_step: got %b want %b", check_err, exp_err);
    end
    tick();
    checks++;
    if (check_err !== exp_err) begin
      errors++;
      $display("FAIL check_sticky: got %b want %b", check_err, exp_err);
    end
  endtask

  task automatic test_reset_mid_load();
    send(2'b01, 1'b1, 4'h9, 6'd5);
    checks++;
    if (st !== 5'b01010) begin
      errors++;
      $display("FAIL pre_reset_load: got %b want 01010", st);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({st, control_value, count_input, check_err} !== '0) begin
      errors++;
      $display("FAIL reset_async: got st=%b cv=%b ci=%h e=%b want all zero",
               st, control_value, count_input, check_err);
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({st, count_input} !== {5'b10000, 4'h0}) begin
      errors++;
      $display("FAIL reset_no_init: got st=%b ci=%h want 10000 0", st, count_input);
    end
  endtask

  initial begin
    reset            = 1'b0;
    game_clr         = 1'b0;
    WINNER           = 1'b0;
    LOSER            = 1'b0;
    GAMEOVER         = 1'b0;
    WHO              = 2'b00;
    count            = 4'd0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_mode  = 2'b00;
    cmd_if.cmd_load  = 1'b0;
    cmd_if.cmd_value = 4'h0;
    cmd_if.cmd_len   = 6'd0;

    test_reset();
    test_load_run();
    test_zero_len();
    test_saturate();
    test_gameover();
    test_gameover_idle();
    test_check();
    test_reset_mid_load();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter LEN_W, default 6: width of the run-length field.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-006 cmd_mode  in  2  counter mode: 00 +1, 01 +2, 10 -1, 11 -2.
REQ-007 cmd_load  in  1  load cmd_value into the counter before running.
REQ-008 cmd_value  in  4  initial count for the load.
REQ-009 cmd_len  in  LEN_W  RUN cycles for this segment; 0 is treated as 1.
REQ-010 game_clr  in  1  leaves HALT and restarts the game.
REQ-011 WINNER, LOSER, GAMEOVER  in  1 each  counter status inputs.
REQ-012 WHO  in  2  counter winner code (01 loser side, 10 winner side).
REQ-013 count  in  4  counter value.
REQ-014 control_value  out  2  mode driven to the counter.
REQ-015 INIT  out  1  load strobe to the counter.
REQ-016 count_input  out  4  load value to the counter.
REQ-017 ctr_reset  out  1  active-high reset pulse to the counter.
REQ-018 busy  out  1  high in LOAD or RUN.
REQ-019 done  out  1  high in HALT.
REQ-020 result_who  out  2  WHO captured at GAMEOVER.
REQ-021 win_seen, lose_seen  out  4 each  saturating event tallies.
REQ-022 check_err  out  1  sticky count-prediction error.

Function
REQ-023 The FSM SHALL have the states IDLE, LOAD, RUN and HALT; every output SHALL be registered.
REQ-024 In IDLE, cmd_ready SHALL be 1 and cmd_ready SHALL be 0 in every other state.
REQ-025 On acceptance, mode, value and len (0→1) SHALL be latched; next state is LOAD if cmd_load, else RUN.
REQ-026 In LOAD, INIT=1 and count_input=latched value for exactly one cycle, then RUN.
REQ-027 In RUN, control_value SHALL equal the latched mode, INIT=0, and the remaining-length counter SHALL decrement once per cycle; on its last cycle the next state is IDLE.
REQ-028 control_value SHALL hold the last latched mode in IDLE and HALT.
REQ-029 WINNER or LOSER sampled high in LOAD or RUN SHALL increment win_seen or lose_seen respectively, saturating at 15; simultaneous highs increment both.
REQ-030 GAMEOVER sampled high in any state except HALT SHALL force HALT next cycle, capture WHO into result_who, and override segment end or a pending acceptance.
REQ-031 In HALT, done=1 and the block SHALL ignore commands; game_clr SHALL pulse ctr_reset for one cycle, clear tallies, result_who and check_err, and return to IDLE.
REQ-032 game_clr outside HALT SHALL have no effect.

Reset
REQ-033 While reset=0, the state SHALL be IDLE and control_value=00, INIT=0, count_input=0, ctr_reset=0, busy=0, done=0, result_who=00, tallies=0, check_err=0, cmd_ready=0; cmd_ready rises on the first edge after release.
REQ-034 Reset asserted mid-segment SHALL abandon the segment with no INIT or ctr_reset pulse emitted.

Configuration
REQ-035 With GAME_SEQ_CHECK_EN defined, from the second RUN cycle of each segment onward check_err SHALL set when count ≠ (previous-cycle count + mode step) mod 16; it stays set until reset or game_clr.
REQ-036 Without GAME_SEQ_CHECK_EN, check_err SHALL be constant 0 and no prediction logic SHALL exist.

Verification
REQ-037 Command mode=00, load=1, value=1101, len=4 -> one-cycle INIT with count_input=1101, then 4 RUN cycles with control_value=00, then IDLE with cmd_ready=1.
REQ-038 Command mode=01, load=0, len=0 -> exactly one RUN cycle, no INIT pulse.
REQ-039 WINNER high in 17 RUN cycles -> win_seen reaches 15 and holds at 15.
REQ-040 GAMEOVER=1 with WHO=10 mid-RUN -> HALT next cycle, done=1, result_who=10, cmd_valid ignored; game_clr -> one-cycle ctr_reset, tallies 0, IDLE.
REQ-041 With GAME_SEQ_CHECK_EN, mode=10 while count steps 5,4,3,7 -> check_err=1 after the 7, remaining set; without the macro, check_err=0 throughout.
REQ-042 reset=0 asserted during LOAD -> all outputs reach their reset values immediately, with no further INIT pulse.
